// File: rtl/neopixel_write_arbiter.sv
// Round-robin arbiter that shares the neopixel ctrl write port among C_NUM_REQ requesters.
// Sequences the strobe / ready-drop / ready-return handshake and bounds each wait with a watchdog.
module neopixel_write_arbiter #(
  parameter int C_NUM_REQ        = 4,
  parameter int C_PIXELS         = 12,
  parameter int C_TIMEOUT_CYCLES = 4096
) (
  input  logic                    ctrl_clock,
  input  logic                    ctrl_reset_n,
  input  logic [C_NUM_REQ-1:0]    req_valid,
  input  logic [8*C_NUM_REQ-1:0]  req_address,
  input  logic [24*C_NUM_REQ-1:0] req_data,
  output logic [C_NUM_REQ-1:0]    req_done,
  output logic [C_NUM_REQ-1:0]    req_error,
  output logic                    ctrl_write,
  output logic [31:0]             ctrl_address,
  output logic [31:0]             ctrl_write_data,
  input  logic                    ctrl_ready,
  output logic                    busy,
  output logic                    timeout_flag
);

  localparam int IDX_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int WD_W  = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(C_TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       win_q;
  logic [7:0]             addr_q;
  logic [23:0]            data_q;
  logic [WD_W-1:0]        wd_count_q;
  logic                   ctrl_write_q;
  logic [31:0]            ctrl_address_q;
  logic [31:0]            ctrl_write_data_q;
  logic [C_NUM_REQ-1:0]   req_done_q;
  logic [C_NUM_REQ-1:0]   req_error_q;
  logic                   busy_q;
  logic                   timeout_flag_q;

  // Candidate gi is the requester gi positions above rr_ptr, wrapping modulo C_NUM_REQ.
  logic [IDX_W-1:0]       cand_idx [C_NUM_REQ];
  logic [C_NUM_REQ-1:0]   cand_hit;

  for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum           = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IDX_W+1)'(C_NUM_REQ))
                           ? IDX_W'(sum - (IDX_W+1)'(C_NUM_REQ))
                           : sum[IDX_W-1:0];
    assign cand_hit[gi]  = req_valid[cand_idx[gi]];
  end

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  logic             addr_ok;
  logic [IDX_W-1:0] win_next;

  assign addr_ok  = ({24'd0, addr_q} < 32'(C_PIXELS));
  assign win_next = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;

  always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q           <= S_IDLE;
      rr_ptr_q          <= '0;
      win_q             <= '0;
      addr_q            <= '0;
      data_q            <= '0;
      wd_count_q        <= '0;
      ctrl_write_q      <= 1'b0;
      ctrl_address_q    <= '0;
      ctrl_write_data_q <= '0;
      req_done_q        <= '0;
      req_error_q       <= '0;
      busy_q            <= 1'b0;
      timeout_flag_q    <= 1'b0;
    end else begin
      ctrl_write_q <= 1'b0;
      req_done_q   <= '0;
      req_error_q  <= '0;
      case (state_q)
        S_IDLE: begin
          // Only grant while the engine is ready so a strobe never lands on a busy engine.
          if (grant_any && ctrl_ready) begin
            win_q   <= grant_idx;
            addr_q  <= req_address[8*grant_idx +: 8];
            data_q  <= req_data[24*grant_idx +: 24];
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (addr_ok) begin
            ctrl_write_q      <= 1'b1;
            ctrl_address_q    <= {24'd0, addr_q};
            ctrl_write_data_q <= {8'd0, data_q};
            state_q           <= S_ISSUE;
          end else begin
            req_error_q[win_q] <= 1'b1;
            state_q            <= S_ERROR;
          end
        end
        S_ISSUE: begin
          wd_count_q <= '0;
          state_q    <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!ctrl_ready) begin
            wd_count_q <= '0;
            state_q    <= S_WAIT_HIGH;
          end else if (wd_count_q == WD_LAST) begin
            timeout_flag_q     <= 1'b1;
            req_error_q[win_q] <= 1'b1;
            state_q            <= S_ERROR;
          end else begin
            wd_count_q <= wd_count_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (ctrl_ready) begin
            req_done_q[win_q] <= 1'b1;
            state_q           <= S_DONE;
          end else if (wd_count_q == WD_LAST) begin
            timeout_flag_q     <= 1'b1;
            req_error_q[win_q] <= 1'b1;
            state_q            <= S_ERROR;
          end else begin
            wd_count_q <= wd_count_q + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          rr_ptr_q <= win_next;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_write      = ctrl_write_q;
  assign ctrl_address    = ctrl_address_q;
  assign ctrl_write_data = ctrl_write_data_q;
  assign req_done        = req_done_q;
  assign req_error       = req_error_q;
  assign busy            = busy_q;
  assign timeout_flag    = timeout_flag_q;

endmodule

// File: tb/tb_neopixel_write_arbiter.sv
// Directed bench for neopixel_write_arbiter: a simple pixel-engine ready model plus
// hand-computed expectations for latency, grant order, range errors, timeout and reset.
module tb_neopixel_write_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [8*N-1:0]  req_address = '0;
  logic [24*N-1:0] req_data = '0;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_error;
  logic            ctrl_write;
  logic [31:0]     ctrl_address;
  logic [31:0]     ctrl_write_data;
  logic            ctrl_ready = 1'b1;
  logic            busy;
  logic            timeout_flag;

  int total = 0;
  int bad = 0;

  // Engine model: ready drops 2 cycles after a strobe and stays low for low_len cycles.
  int since = 100;
  int low_len = 5;
  bit stuck = 1'b0;
  bit force_low = 1'b0;

  always #5 clk = ~clk;

  neopixel_write_arbiter #(
    .C_NUM_REQ       (N),
    .C_PIXELS        (12),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .ctrl_clock     (clk),
    .ctrl_reset_n   (rst_n),
    .req_valid      (req_valid),
    .req_address    (req_address),
    .req_data       (req_data),
    .req_done       (req_done),
    .req_error      (req_error),
    .ctrl_write     (ctrl_write),
    .ctrl_address   (ctrl_address),
    .ctrl_write_data(ctrl_write_data),
    .ctrl_ready     (ctrl_ready),
    .busy           (busy),
    .timeout_flag   (timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ctrl_write === 1'b1) since = 0;
    else if (since < 1000) since++;
    if (force_low) ctrl_ready = 1'b0;
    else if (!stuck && since >= 2 && since < 2 + low_len) ctrl_ready = 1'b0;
    else ctrl_ready = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [23:0] d);
    req_address[8*k +: 8] = a;
    req_data[24*k +: 24]  = d;
    req_valid[k]          = 1'b1;
  endtask

  // Tick until a response pulse appears (or the budget runs out), noting strobes seen.
  task automatic run_resp(input int budget, output int n, output logic [3:0] dn,
                          output logic [3:0] er, output int writes,
                          output logic [31:0] wa, output logic [31:0] wd);
    n = 0; writes = 0; dn = '0; er = '0; wa = '0; wd = '0;
    while (n < budget) begin
      tick();
      n++;
      if (ctrl_write === 1'b1) begin
        writes++;
        wa = ctrl_address;
        wd = ctrl_write_data;
      end
      if (req_done !== '0 || req_error !== '0) begin
        dn = req_done;
        er = req_error;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int writes;
    logic [3:0] dn;
    logic [3:0] er;
    logic [31:0] wa;
    logic [31:0] wd;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(ctrl_write), 32'd0);
    chk("rst_addr", ctrl_address, 32'd0);
    chk("rst_data", ctrl_write_data, 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_error", 32'(req_error), 32'd0);
    chk("rst_tflag", 32'(timeout_flag), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Fairness: everyone held valid; rr_ptr starts at 0.
    for (int k = 0; k < N; k++) set_req(k, 8'(k + 1), {8'(k + 1), 16'hA5A5});
    for (int g = 0; g < 6; g++) begin
      run_resp(50, n, dn, er, writes, wa, wd);
      chk($sformatf("fair_grant%0d", g), 32'(dn), 32'(1 << (g % 4)));
      chk($sformatf("fair_addr%0d", g), wa, 32'(g % 4 + 1));
      chk($sformatf("fair_data%0d", g), wd, {8'd0, 8'(g % 4 + 1), 16'hA5A5});
      if (g == 5) req_valid = '0;
    end
    tick();
    chk("fair_idle", 32'(busy), 32'd0);
    tick();
    chk("fair_nogrant", 32'(busy), 32'd0);

    // Single write: done arrives one cycle after ready returns.
    set_req(0, 8'd3, 24'hFF8000);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid[0] = 1'b0;
    chk("single_lat", 32'(n), 32'd10);
    chk("single_done", 32'(dn), 32'h1);
    chk("single_err", 32'(er), 32'h0);
    chk("single_writes", 32'(writes), 32'd1);
    chk("single_addr", wa, 32'd3);
    chk("single_data", wd, 32'h00FF8000);
    tick();
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_hold", ctrl_address, 32'd3);

    // Busy engine: no grant while ready is low.
    force_low = 1'b1;
    ctrl_ready = 1'b0;
    set_req(1, 8'd7, 24'h00FF00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("eng_busy%0d", i), 32'(busy), 32'd0);
      chk($sformatf("eng_write%0d", i), 32'(ctrl_write), 32'd0);
    end
    force_low = 1'b0;
    ctrl_ready = 1'b1;
    tick();
    chk("eng_grant", 32'(busy), 32'd1);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid[1] = 1'b0;
    chk("eng_lat", 32'(n), 32'd9);
    chk("eng_done", 32'(dn), 32'h2);
    chk("eng_addr", wa, 32'd7);
    chk("eng_data", wd, 32'h0000FF00);
    tick();

    // Range error: address equal to the pixel count.
    set_req(2, 8'd12, 24'h123456);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid[2] = 1'b0;
    chk("range_lat", 32'(n), 32'd2);
    chk("range_err", 32'(er), 32'h4);
    chk("range_done", 32'(dn), 32'h0);
    chk("range_writes", 32'(writes), 32'd0);
    chk("range_tflag", 32'(timeout_flag), 32'd0);
    tick();
    chk("range_busy", 32'(busy), 32'd0);
    chk("range_errclr", 32'(req_error), 32'd0);

    // Timeout: ready never drops after the strobe.
    stuck = 1'b1;
    set_req(3, 8'd5, 24'h0000FF);
    run_resp(60, n, dn, er, writes, wa, wd);
    req_valid[3] = 1'b0;
    chk("tmo_lat", 32'(n), 32'd19);
    chk("tmo_err", 32'(er), 32'h8);
    chk("tmo_done", 32'(dn), 32'h0);
    chk("tmo_writes", 32'(writes), 32'd1);
    chk("tmo_tflag", 32'(timeout_flag), 32'd1);
    stuck = 1'b0;
    tick();
    chk("tmo_sticky", 32'(timeout_flag), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Next request proceeds normally; highest valid address.
    set_req(0, 8'd11, 24'h010203);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid[0] = 1'b0;
    chk("post_lat", 32'(n), 32'd10);
    chk("post_done", 32'(dn), 32'h1);
    chk("post_addr", wa, 32'd11);
    chk("post_data", wd, 32'h00010203);
    chk("post_tflag", 32'(timeout_flag), 32'd1);
    tick();

    // Reset while waiting for ready to return (rr_ptr is 1 beforehand).
    low_len = 20;
    set_req(2, 8'd6, 24'hABCDEF);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_nodone", 32'(req_done), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", ctrl_address, 32'd0);
    chk("mid_rst_data", ctrl_write_data, 32'd0);
    chk("mid_rst_tflag", 32'(timeout_flag), 32'd0);
    req_valid = '0;
    tick();
    chk("mid_rst_done", 32'(req_done), 32'd0);
    tick();
    rst_n = 1'b1;
    since = 100;
    low_len = 5;
    ctrl_ready = 1'b1;
    tick();
    chk("mid_idle", 32'(busy), 32'd0);

    set_req(0, 8'd1, 24'h111111);
    set_req(3, 8'd9, 24'h999999);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid[0] = 1'b0;
    chk("rr_reset_win", 32'(dn), 32'h1);
    chk("rr_reset_addr", wa, 32'd1);
    run_resp(50, n, dn, er, writes, wa, wd);
    req_valid = '0;
    chk("rr_next_win", 32'(dn), 32'h8);
    chk("rr_next_addr", wa, 32'd9);
    chk("rr_next_data", wd, 32'h00999999);
    tick();
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
